ifetch_unit: RTL and testbench

//  Instruction fetch stage; produces the op/func/rt fields consumed by the control unit.

---
 rtl/ifetch_unit.sv | 142 ++++++++++++++
 tb/tb_ifetch_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, issues one-outstanding word reads to imem, holds the fetched word for decode.
// Optional build macro IFETCH_ALIGN_CHK_EN: misaligned redirect targets raise err_misalign and halt fetch.
module ifetch_unit #(
    parameter int          AW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [5:0]    op,
    output logic [4:0]    rt,
    output logic [5:0]    func,
    output logic [AW-1:0] instr_pc,
    output logic [AW-1:0] pc_plus4,
    output logic          bus_err
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    output logic          err_misalign
`endif
);

    // Decode handshake: instr_valid rises only with a fresh word, payload holds steady while
    // instr_valid && !instr_ready, and the word is consumed on the cycle both are high.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          kill;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_inc;
    logic          timeout_hit;
    logic          take;
    logic          redir_bad;
    logic          halted;

`ifdef IFETCH_ALIGN_CHK_EN
    assign target    = redirect_pc;
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halted    = bus_err || err_misalign;
`else
    assign target    = redirect_pc & ~AW'(3);
    assign redir_bad = 1'b0;
    assign halted    = bus_err;
`endif

    assign wait_cnt_inc = wait_cnt + CW'(1);
    assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == CW'(TIMEOUT));
    // A response is kept only if no redirect is pending or arriving with it.
    assign take = (state == WAIT) && imem_rvalid && !kill && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!halted) state_nxt = REQ;
            REQ:  if (imem_gnt) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid) state_nxt = take ? HOLD : REQ;
                else if (timeout_hit) state_nxt = IDLE;
            end
            HOLD: if (instr_ready || redirect_valid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        if (redir_bad) state_nxt = IDLE;
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = pc;
        op        = instr[31:26];
        rt        = instr[20:16];
        func      = instr[5:0];
        pc_plus4  = instr_pc + AW'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RST_PC;
            instr       <= 32'h0;
            instr_pc    <= RST_PC;
            instr_valid <= 1'b0;
            kill        <= 1'b0;
            wait_cnt    <= '0;
            bus_err     <= 1'b0;
        end else begin
            if (redirect_valid) pc <= target;
            else if (take) pc <= pc + AW'(4);

            if (state == REQ && imem_gnt) begin
                kill     <= redirect_valid;
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                if (imem_rvalid) kill <= 1'b0;
                else if (redirect_valid) kill <= 1'b1;
                if (!imem_rvalid) wait_cnt <= wait_cnt_inc;
            end

            if (state == WAIT && !imem_rvalid && timeout_hit) bus_err <= 1'b1;

            if (take) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (state == HOLD && (instr_ready || redirect_valid)) begin
                instr_valid <= 1'b0;
            end
            if (redir_bad) instr_valid <= 1'b0;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misalign <= 1'b0;
        end else if (redir_bad) begin
            err_misalign <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: bench-side imem responder plus an in-order PC scoreboard.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  func;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        bus_err;
`ifdef IFETCH_ALIGN_CHK_EN
    logic        err_misalign;
`endif

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .op(op), .rt(rt), .func(func),
        .instr_pc(instr_pc), .pc_plus4(pc_plus4), .bus_err(bus_err)
`ifdef IFETCH_ALIGN_CHK_EN
        , .err_misalign(err_misalign)
`endif
    );

    int errors = 0;
    int checks = 0;
    int n_hs   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [31:0] redir_target(input logic [31:0] a);
`ifdef IFETCH_ALIGN_CHK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    // ---------------- imem responder ----------------
    int          mem_lat   = 0;
    int          gnt_delay = 0;
    bit          mem_mute  = 1'b0;
    logic        pend;
    logic [31:0] pend_addr;
    int          lat_cnt;
    int          gw_cnt;
    logic [31:0] grant_q[$];

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pend = 1'b0; pend_addr = 32'h0; lat_cnt = 0; gw_cnt = 0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            imem_gnt    = 1'b0;
            if (!rst_n) begin
                pend   = 1'b0;
                gw_cnt = gnt_delay;
            end else begin
                if (pend) begin
                    if (lat_cnt > 0) lat_cnt--;
                    else if (!mem_mute) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(pend_addr);
                        pend        = 1'b0;
                    end
                end
                if (imem_req) begin
                    if (gw_cnt == 0) begin
                        imem_gnt  = 1'b1;
                        pend      = 1'b1;
                        pend_addr = imem_addr;
                        lat_cnt   = mem_lat;
                        grant_q.push_back(imem_addr);
                        gw_cnt    = gnt_delay;
                    end else begin
                        gw_cnt--;
                    end
                end else begin
                    gw_cnt = gnt_delay;
                end
            end
        end
    end

    // ---------------- scoreboard / compare process ----------------
    // Model: decode sees consecutive word PCs; a redirect makes the target the next PC seen.
    logic [31:0] exp_q[$];
    logic [31:0] sb_pc;
    logic [31:0] sb_word;
    logic        p_valid, p_ready, p_redir;
    logic [31:0] p_instr, p_pc;

    initial begin
        p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0; p_instr = 32'h0; p_pc = 32'h0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(32'h0000_3000);
        end else begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hs_scoreboard: got pc 0x%08h expected no delivery", instr_pc);
                end else begin
                    sb_pc   = exp_q.pop_front();
                    sb_word = mem_word(sb_pc);
                    chk("hs_instr_pc", instr_pc, sb_pc);
                    chk("hs_instr", instr, sb_word);
                    chk("hs_op", 32'(op), 32'(sb_word[31:26]));
                    chk("hs_rt", 32'(rt), 32'(sb_word[20:16]));
                    chk("hs_func", 32'(func), 32'(sb_word[5:0]));
                    chk("hs_pc_plus4", pc_plus4, sb_pc + 32'd4);
                    exp_q.push_back(sb_pc + 32'd4);
                    n_hs++;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redir_target(redirect_pc));
            end
            chk("req_while_valid", 32'(imem_req && instr_valid), 32'd0);
            if (p_valid && !p_ready && !p_redir) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_instr", instr, p_instr);
                chk("hold_pc", instr_pc, p_pc);
            end
        end
        p_valid = instr_valid && rst_n;
        p_ready = instr_ready;
        p_redir = redirect_valid;
        p_instr = instr;
        p_pc    = instr_pc;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(imem_req && imem_gnt) && n < 60);
        if (!(imem_req && imem_gnt)) begin
            checks++; errors++;
            $display("FAIL wait_gnt: got no grant after %0d cycles, required one", n);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!instr_valid && n < 60);
        if (!instr_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid: got instr_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_grant_q();
        int n = 0;
        do begin @(negedge clk); n++; end while (grant_q.size() == 0 && n < 60);
        if (grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wait_grant_q: got no grant after %0d cycles, required one", n);
            grant_q.push_back(32'hDEAD_BEEF);
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic rdy);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        instr_ready    = rdy;
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
    endtask

    task automatic check_reset();
        step();
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0000_3000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_pc", instr_pc, 32'h0000_3000);
        chk("rst_pc_plus4", pc_plus4, 32'h0000_3004);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
`ifdef IFETCH_ALIGN_CHK_EN
        chk("rst_err_misalign", 32'(err_misalign), 32'd0);
`endif
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] tgts [2];
        logic [31:0] words[2];
        int hs0;
        bit seen;
        tgts[0] = 32'h0000_3100; words[0] = 32'h8FEF_3100;
        tgts[1] = 32'h0000_3200; words[1] = 32'h8CEF_3200;
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        check_reset();

        // First fetch: address, two-cycle latency from grant, decoded fields.
        wait_gnt();
        chk("first_addr", imem_addr, 32'h0000_3000);
        @(negedge clk);
        chk("lat_gnt_plus1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("lat_gnt_plus2", 32'(instr_valid), 32'd1);
        chk("first_instr", instr, 32'h8EEF_3000);
        chk("first_op", 32'(op), 32'h23);
        chk("first_rt", 32'(rt), 32'h0F);
        chk("first_func", 32'(func), 32'h00);
        chk("first_pc_plus4", pc_plus4, 32'h0000_3004);

        // Decode stalls five cycles.
        repeat (5) step();
        @(negedge clk);
        chk("stall_no_req", 32'(imem_req), 32'd0);
        chk("stall_instr_pc", instr_pc, 32'h0000_3000);
        step(); instr_ready = 1'b1;
        repeat (15) step();
        instr_ready = 1'b0;

        // Redirect during WAIT: rvalid same cycle (lat 0) and delayed (lat 2).
        for (int i = 0; i < 2; i++) begin
            wait_valid();
            mem_lat = (i == 0) ? 0 : 2;
            step(); instr_ready = 1'b1;
            wait_gnt();
            grant_q.delete();
            do_redirect(tgts[i], 1'b0);
            wait_grant_q();
            chk("wait_redir_addr", grant_q[0], tgts[i]);
            wait_valid();
            chk("wait_redir_pc", instr_pc, tgts[i]);
            chk("wait_redir_instr", instr, words[i]);
        end
        mem_lat = 0;

        // Redirect in HOLD together with instr_ready: held word consumed once.
        hs0 = n_hs;
        do_redirect(32'h0000_3400, 1'b1);
        @(negedge clk);
        chk("hold_rdy_redir_drop", 32'(instr_valid), 32'd0);
        wait_valid();
        chk("hold_rdy_redir_hs", 32'(n_hs - hs0), 32'd1);
        chk("hold_rdy_redir_pc", instr_pc, 32'h0000_3400);
        chk("hold_rdy_redir_instr", instr, 32'h8AEF_3400);

        // Redirect in HOLD without instr_ready: held word dropped.
        hs0 = n_hs;
        do_redirect(32'h0000_3500, 1'b0);
        @(negedge clk);
        chk("hold_redir_drop", 32'(instr_valid), 32'd0);
        wait_valid();
        chk("hold_redir_hs", 32'(n_hs - hs0), 32'd0);
        chk("hold_redir_pc", instr_pc, 32'h0000_3500);

        // Redirect in REQ without grant: address follows next cycle.
        gnt_delay = 3;
        grant_q.delete();
        step(); instr_ready = 1'b1;
        step(); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3600;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("req_redir_req", 32'(imem_req), 32'd1);
        chk("req_redir_addr", imem_addr, 32'h0000_3600);
        wait_gnt();
        gnt_delay = 0;
        chk("req_redir_grants", 32'(grant_q.size()), 32'd1);
        chk("req_redir_gaddr", grant_q[0], 32'h0000_3600);
        wait_valid();
        chk("req_redir_pc", instr_pc, 32'h0000_3600);

        // Redirect in REQ with grant the same cycle: old request killed.
        step(); instr_ready = 1'b1;
        step(); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3700;
        step(); redirect_valid = 1'b0;
        wait_valid();
        chk("req_gnt_redir_pc", instr_pc, 32'h0000_3700);
        chk("req_gnt_redir_instr", instr, 32'h89EF_3700);

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFFC, 1'b0);
        wait_valid();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        chk("wrap_instr", instr, 32'h4113_FFFC);
        grant_q.delete();
        step(); instr_ready = 1'b1;
        wait_grant_q();
        chk("wrap_next_addr", grant_q[0], 32'h0);
        repeat (6) step();
        instr_ready = 1'b0;

`ifndef IFETCH_ALIGN_CHK_EN
        // Low target bits are ignored.
        wait_valid();
        do_redirect(32'h0000_3202, 1'b0);
        wait_valid();
        chk("unaligned_forced_pc", instr_pc, 32'h0000_3200);
`endif

        // Response timeout.
        wait_valid();
        mem_mute = 1'b1;
        step(); instr_ready = 1'b1;
        wait_gnt();
        repeat (5) @(negedge clk);
        chk("timeout_early", 32'(bus_err), 32'd0);
        repeat (12) @(negedge clk);
        chk("timeout_bus_err", 32'(bus_err), 32'd1);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (imem_req) seen = 1'b1; end
        chk("timeout_no_req", 32'(seen), 32'd0);
        mem_mute = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (instr_valid) seen = 1'b1; end
        chk("timeout_late_rvalid", 32'(seen), 32'd0);
        chk("timeout_sticky", 32'(bus_err), 32'd1);

        check_reset();
        wait_gnt();
        chk("restart_addr", imem_addr, 32'h0000_3000);

`ifdef IFETCH_ALIGN_CHK_EN
        wait_valid();
        do_redirect(32'h0000_3102, 1'b0);
        @(negedge clk);
        chk("misalign_err", 32'(err_misalign), 32'd1);
        chk("misalign_valid", 32'(instr_valid), 32'd0);
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (imem_req) seen = 1'b1; end
        chk("misalign_no_req", 32'(seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
